// File: rtl/mult_mnbit_seq.sv
// mult_mnbit_seq -- sequential M x N shift-and-add multiplier.
//
// One multiplier bit is consumed per clock, which keeps the garbled-circuit
// netlist small at the cost of N cycles of latency.
// g_input is the garbler operand (multiplicand) and e_input is the
// evaluator operand (multiplier).
//
// Ports:
//   clk      system clock, rising-edge
//   rst      asynchronous active-high reset
//   start    request a multiply (accepted in IDLE or DONE, ignored in RUN)
//   g_input  multiplicand, M bits, captured on accepted start
//   e_input  multiplier, N bits, captured on accepted start
//   o        product, M+N bits, updated on DONE entry and held otherwise
//   busy     high in every RUN (iteration) cycle
//   done     one-cycle pulse in the DONE cycle, when o carries a new product
//
// Parameters: M, N operand widths; SIGNED selects a two's-complement product.

module mult_mnbit_seq #(
    parameter int M      = 8,
    parameter int N      = 8,
    parameter int SIGNED = 0
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           start,
    input  logic [M-1:0]   g_input,
    input  logic [N-1:0]   e_input,
    output logic [M+N-1:0] o,
    output logic           busy,
    output logic           done
);

    localparam int W  = M + N;
    // Counter must hold 0..N-1; keep at least one bit for N = 1.
    localparam int CW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t          state_reg;
    state_t          state_next;
    logic [M-1:0]    a_reg;
    logic [N-1:0]    b_reg;
    logic [W-1:0]    acc_reg;
    logic [CW-1:0]   count_reg;
    logic [W-1:0]    o_reg;

    logic [W-1:0]    a_ext;
    logic [W-1:0]    partial;
    logic [W-1:0]    acc_step;
    logic            last_iter;
    logic            accept;

    // Multiplicand widened to the product width: the upper N bits replicate
    // the sign bit in signed mode and are zero otherwise.
    assign a_ext[M-1:0] = a_reg;
    generate
        for (genvar gi = M; gi < W; gi++) begin : g_ext
            assign a_ext[gi] = (SIGNED != 0) ? a_reg[M-1] : 1'b0;
        end
    endgenerate

    assign last_iter = (count_reg == CW'(N - 1));
    assign partial   = b_reg[count_reg] ? (a_ext << count_reg) : '0;

    // In two's complement the multiplier MSB carries weight -2^(N-1), so its
    // partial product is subtracted rather than added.
    assign acc_step  = ((SIGNED != 0) && last_iter) ? (acc_reg - partial)
                                                    : (acc_reg + partial);

    assign accept    = start && (state_reg != RUN);

    always_comb begin
        state_next = state_reg;
        busy       = 1'b0;
        done       = 1'b0;
        case (state_reg)
            IDLE: begin
                if (start) state_next = RUN;
            end
            RUN: begin
                busy = 1'b1;
                if (last_iter) state_next = DONE;
            end
            DONE: begin
                done       = 1'b1;
                // A start here chains straight into the next operation.
                state_next = start ? RUN : IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= IDLE;
            a_reg     <= '0;
            b_reg     <= '0;
            acc_reg   <= '0;
            count_reg <= '0;
            o_reg     <= '0;
        end else begin
            state_reg <= state_next;
            if (accept) begin
                a_reg     <= g_input;
                b_reg     <= e_input;
                acc_reg   <= '0;
                count_reg <= '0;
            end else if (state_reg == RUN) begin
                acc_reg   <= acc_step;
                count_reg <= count_reg + 1'b1;
                // Product is registered on the edge that enters DONE.
                if (last_iter) o_reg <= acc_step;
            end
        end
    end

    assign o = o_reg;

endmodule

// File: tb/tb_mult_mnbit_seq.sv
// Testbench for mult_mnbit_seq: three instances (8x8 unsigned, 8x8 signed,
// 8x4 unsigned) sharing clock and reset, directed steps plus randomized
// operands checked against plain integer products.

module tb_mult_mnbit_seq;

    logic        clk;
    logic        rst;
    logic [2:0]  start;
    logic [7:0]  g [3];
    logic [7:0]  e [3];
    logic [15:0] o0;
    logic [15:0] o1;
    logic [11:0] o2;
    logic [2:0]  busy;
    logic [2:0]  done;

    int checks = 0;
    int errors = 0;

    mult_mnbit_seq #(.M(8), .N(8), .SIGNED(0)) u0 (
        .clk(clk), .rst(rst), .start(start[0]), .g_input(g[0]),
        .e_input(e[0]), .o(o0), .busy(busy[0]), .done(done[0]));

    mult_mnbit_seq #(.M(8), .N(8), .SIGNED(1)) u1 (
        .clk(clk), .rst(rst), .start(start[1]), .g_input(g[1]),
        .e_input(e[1]), .o(o1), .busy(busy[1]), .done(done[1]));

    mult_mnbit_seq #(.M(8), .N(4), .SIGNED(0)) u2 (
        .clk(clk), .rst(rst), .start(start[2]), .g_input(g[2]),
        .e_input(e[2][3:0]), .o(o2), .busy(busy[2]), .done(done[2]));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [15:0] get_o(input int sel);
        case (sel)
            0:       return o0;
            1:       return o1;
            default: return {4'h0, o2};
        endcase
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Present operands on a falling edge; the next rising edge accepts them.
    // Afterwards the inputs are scrambled to show they are no longer used.
    task automatic begin_op(input int sel, input logic [7:0] gv, input logic [7:0] ev,
                            input bit keep);
        @(negedge clk);
        start[sel] = 1'b1;
        g[sel] = gv;
        e[sel] = ev;
        @(posedge clk);
        #1;
        if (!keep) start[sel] = 1'b0;
        g[sel] = 8'($urandom);
        e[sel] = 8'($urandom);
    endtask

    // Count cycles after acceptance until done; expects n busy cycles and
    // done in cycle n+1, then checks the product.
    task automatic wait_done(input int sel, input logic [15:0] exp, input int n,
                             input string tag);
        int cyc = 0;
        int bcnt = 0;
        bit both = 0;
        bit seen = 0;
        while (!seen && cyc < 40) begin
            @(negedge clk);
            cyc++;
            if (busy[sel]) bcnt++;
            if (busy[sel] && done[sel]) both = 1;
            if (done[sel]) seen = 1;
        end
        check({tag, "_latency"}, cyc, n + 1);
        check({tag, "_busycycles"}, bcnt, n);
        check({tag, "_busydone"}, 32'(both), 0);
        check({tag, "_o"}, get_o(sel), exp);
        $display("op %-10s dut=%0d o=%04h exp=%04h cycles=%0d", tag, sel, get_o(sel), exp, cyc);
    endtask

    initial begin
        logic [7:0] gv;
        logic [7:0] ev;
        int         p;
        int         bad;

        rst   = 1'b1;
        start = '0;
        for (int i = 0; i < 3; i++) begin
            g[i] = '0;
            e[i] = '0;
        end
        #2;
        check("reset_o0", o0, 0);
        check("reset_o1", o1, 0);
        check("reset_o2", o2, 0);
        check("reset_busy", busy, 0);
        check("reset_done", done, 0);
        @(negedge clk);
        rst = 1'b0;

        // Unsigned 8x8.
        begin_op(0, 8'hFF, 8'hFF, 0);
        wait_done(0, 16'hFE01, 8, "u_ffxff");
        begin_op(0, 8'h42, 8'h47, 0);
        wait_done(0, 16'h124E, 8, "u_42x47");

        // Hold: o stays, no busy/done while idle.
        bad = 0;
        repeat (20) begin
            @(negedge clk);
            if (o0 !== 16'h124E || busy[0] !== 1'b0 || done[0] !== 1'b0) bad++;
        end
        check("hold_idle", bad, 0);

        // Signed 8x8.
        begin_op(1, 8'hFF, 8'h47, 0);
        wait_done(1, 16'hFFB9, 8, "s_ffx47");
        begin_op(1, 8'h80, 8'h80, 0);
        wait_done(1, 16'h4000, 8, "s_80x80");
        begin_op(1, 8'h80, 8'h7F, 0);
        wait_done(1, 16'hC080, 8, "s_80x7f");

        // 8x4 unsigned.
        begin_op(2, 8'hFF, 8'h0F, 0);
        wait_done(2, 16'h0EF1, 4, "m8n4_ffxf");

        // Handshake: start held during RUN is ignored; start in DONE chains.
        begin_op(0, 8'h47, 8'h47, 1);
        g[0] = 8'h11;
        e[0] = 8'h22;
        wait_done(0, 16'h13B1, 8, "hs_47x47");
        g[0] = 8'h64;
        e[0] = 8'h13;
        @(posedge clk);
        #1;
        start[0] = 1'b0;
        g[0] = 8'h00;
        e[0] = 8'h00;
        wait_done(0, 16'h076C, 8, "hs_chain");

        // Reset in RUN cycle 4 aborts the operation.
        begin_op(0, 8'h0F, 8'h0F, 0);
        repeat (3) @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("rst_mid_o", o0, 0);
        check("rst_mid_busy", busy[0], 0);
        check("rst_mid_done", done[0], 0);
        @(negedge clk);
        rst = 1'b0;
        bad = 0;
        repeat (12) begin
            @(negedge clk);
            if (done[0] !== 1'b0 || busy[0] !== 1'b0) bad++;
        end
        check("rst_no_done", bad, 0);
        begin_op(0, 8'h0F, 8'h0F, 0);
        wait_done(0, 16'h00E1, 8, "rst_0fx0f");

        // Randomized operands against integer products.
        for (int i = 0; i < 20; i++) begin
            gv = 8'($urandom);
            ev = 8'($urandom);
            p  = int'(gv) * int'(ev);
            begin_op(0, gv, ev, 0);
            wait_done(0, p[15:0], 8, "rnd_u");
        end
        for (int i = 0; i < 20; i++) begin
            int gs;
            int es;
            gv = 8'($urandom);
            ev = 8'($urandom);
            gs = int'($signed(gv));
            es = int'($signed(ev));
            p  = gs * es;
            begin_op(1, gv, ev, 0);
            wait_done(1, p[15:0], 8, "rnd_s");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
